// File: rtl/sram_access_ctrl_if.sv
// Request/response bus for the SRAM access controller.
// master: requester side (drives req_*); slave: the controller.
interface sram_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_addr, req_wen, req_size, req_wdata,
        input  req_ready, resp_valid, resp_error, resp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_size, req_wdata,
        output req_ready, resp_valid, resp_error, resp_rdata
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// SRAM request sequencer: single-beat bus requests in, posted-write
// latch with read forwarding, bank/byte enables and SRAM drive out.
// Ports: CLK, nRST (sync, active-low); bus (slave modport: req_*/resp_*);
//   sram_en, sram_wen, sram_addr, sram_wdata, sram_byte_en to the SRAM;
//   sram_rdata flat per-bank read data (bank i at [32i+31:32i]).
module sram_access_ctrl #(
    parameter int N_SRAM       = 1,
    parameter bit INVERT_CE_EN = 1'b0,
    parameter int ADDR_W       = 12,
    parameter int WAIT_CYCLES  = 0
) (
    input  logic                  CLK,
    input  logic                  nRST,
    sram_access_ctrl_if.slave     bus,
    output logic [N_SRAM-1:0]     sram_en,
    output logic                  sram_wen,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [31:0]           sram_wdata,
    output logic [3:0]            sram_byte_en,
    input  logic [32*N_SRAM-1:0]  sram_rdata
);

    localparam int BW = (N_SRAM > 1) ? $clog2(N_SRAM) : 1;
    localparam logic [N_SRAM-1:0] ONE_N = N_SRAM'(1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, ERR} state_t;

    state_t state, state_nx;

    logic [3:0]        cnt;
    logic              rdy_q;
    logic              last;
    logic              accept;
    logic              size_bad;

    logic [BW-1:0]     req_bank;
    logic [ADDR_W-1:0] req_word;
    logic [3:0]        req_be;

    // Posted-write latch
    logic              lat_v;
    logic [BW-1:0]     lat_bank;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_data;
    logic [3:0]        lat_be;

    // Write that displaced a full latch, waiting for the drain
    logic              stg_v;
    logic [BW-1:0]     stg_bank;
    logic [ADDR_W-1:0] stg_addr;
    logic [31:0]       stg_data;
    logic [3:0]        stg_be;

    logic [BW-1:0]     rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_size;
    logic [1:0]        rd_off;

    logic              resp_valid_q;
    logic              resp_error_q;
    logic [31:0]       resp_rdata_q;

    logic [N_SRAM-1:0] en_act;
    logic [3:0]        be_act;

    logic [31:0]       ram_word;
    logic [31:0]       fwd_m;
    logic              fwd_hit;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       rd_repl;

    logic              unused_addr;

    assign unused_addr = &{1'b0, bus.req_addr};

    assign accept   = bus.req_valid && bus.req_ready;
    assign size_bad = (bus.req_size == 2'd3);
    assign last     = (cnt == 4'(WAIT_CYCLES));

    assign bus.req_ready  = rdy_q && (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_error = resp_error_q;
    assign bus.resp_rdata = resp_rdata_q;

    assign sram_en      = INVERT_CE_EN ? ~en_act : en_act;
    assign sram_byte_en = INVERT_CE_EN ? ~be_act : be_act;

    // Request decode
    always_comb begin
        req_bank = '0;
        if (N_SRAM > 1)
            req_bank = bus.req_addr[ADDR_W+2 +: BW];
        req_word = bus.req_addr[ADDR_W+1:2];
        case (bus.req_size)
            2'd0:    req_be = 4'b0001 << bus.req_addr[1:0];
            2'd1:    req_be = 4'b0011 << {bus.req_addr[1], 1'b0};
            default: req_be = 4'b1111;
        endcase
    end

    // Read data: latch forwarding, then lane replication
    always_comb begin
        ram_word = sram_rdata[32*int'(rd_bank) +: 32];
        fwd_m    = {{8{lat_be[3]}}, {8{lat_be[2]}},
                    {8{lat_be[1]}}, {8{lat_be[0]}}};
        fwd_hit  = lat_v && (lat_bank == rd_bank) &&
                   (lat_addr == rd_addr);
        rd_word  = fwd_hit ? ((lat_data & fwd_m) | (ram_word & ~fwd_m))
                           : ram_word;
        rd_byte  = rd_word[8*rd_off +: 8];
        rd_half  = rd_off[1] ? rd_word[31:16] : rd_word[15:0];
        case (rd_size)
            2'd0:    rd_repl = {4{rd_byte}};
            2'd1:    rd_repl = {2{rd_half}};
            default: rd_repl = rd_word;
        endcase
    end

    // Next state and SRAM drive
    always_comb begin
        state_nx   = state;
        en_act     = '0;
        be_act     = '0;
        sram_wen   = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        case (state)
            IDLE: begin
                // A new request wins over draining the latch, so a read
                // right after a posted write still sees it via forwarding.
                if (accept) begin
                    if (size_bad)
                        state_nx = ERR;
                    else if (!bus.req_wen)
                        state_nx = READ;
                    else if (lat_v)
                        state_nx = DRAIN;
                end else if (lat_v) begin
                    state_nx = DRAIN;
                end
            end
            READ: begin
                en_act    = ONE_N << rd_bank;
                be_act    = 4'hF;
                sram_addr = rd_addr;
                if (last)
                    state_nx = IDLE;
            end
            DRAIN: begin
                en_act     = ONE_N << lat_bank;
                be_act     = lat_be;
                sram_wen   = 1'b1;
                sram_addr  = lat_addr;
                sram_wdata = lat_data;
                if (last)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state        <= IDLE;
            cnt          <= '0;
            rdy_q        <= 1'b0;
            lat_v        <= 1'b0;
            lat_bank     <= '0;
            lat_addr     <= '0;
            lat_data     <= '0;
            lat_be       <= '0;
            stg_v        <= 1'b0;
            stg_bank     <= '0;
            stg_addr     <= '0;
            stg_data     <= '0;
            stg_be       <= '0;
            rd_bank      <= '0;
            rd_addr      <= '0;
            rd_size      <= '0;
            rd_off       <= '0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state        <= state_nx;
            rdy_q        <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            if (state != state_nx)
                cnt <= '0;
            else if (state == READ || state == DRAIN)
                cnt <= cnt + 4'd1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (size_bad) begin
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                            resp_rdata_q <= 32'hBAD1BAD1;
                        end else if (!bus.req_wen) begin
                            rd_bank <= req_bank;
                            rd_addr <= req_word;
                            rd_size <= bus.req_size;
                            rd_off  <= bus.req_addr[1:0];
                        end else if (!lat_v) begin
                            lat_v        <= 1'b1;
                            lat_bank     <= req_bank;
                            lat_addr     <= req_word;
                            lat_data     <= bus.req_wdata;
                            lat_be       <= req_be;
                            resp_valid_q <= 1'b1;
                        end else begin
                            stg_v    <= 1'b1;
                            stg_bank <= req_bank;
                            stg_addr <= req_word;
                            stg_data <= bus.req_wdata;
                            stg_be   <= req_be;
                        end
                    end
                end
                READ: begin
                    if (last) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= rd_repl;
                    end
                end
                DRAIN: begin
                    // The displacing write is acknowledged only once it
                    // owns the latch.
                    if (last) begin
                        lat_v        <= stg_v;
                        lat_bank     <= stg_bank;
                        lat_addr     <= stg_addr;
                        lat_data     <= stg_data;
                        lat_be       <= stg_be;
                        stg_v        <= 1'b0;
                        resp_valid_q <= stg_v;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench for sram_access_ctrl: two banks, active-low enables,
// three wait cycles, with a behavioural SRAM model.
module tb_sram_access_ctrl;

    localparam int W = 3;

    logic        CLK;
    logic        nRST;
    logic [1:0]  sram_en;
    logic        sram_wen;
    logic [11:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_byte_en;
    logic [63:0] sram_rdata;

    sram_access_ctrl_if bus ();

    sram_access_ctrl #(
        .N_SRAM       (2),
        .INVERT_CE_EN (1'b1),
        .ADDR_W       (12),
        .WAIT_CYCLES  (W)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .bus          (bus),
        .sram_en      (sram_en),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_byte_en (sram_byte_en),
        .sram_rdata   (sram_rdata)
    );

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] mem [2][4096];

    logic        poke_en = 1'b0;
    int          poke_b;
    logic [11:0] poke_a;
    logic [31:0] poke_d;

    int          wr_cycles = 0;
    int          en_cycles = 0;
    logic [11:0] last_waddr;
    logic [3:0]  last_be;
    logic [1:0]  last_en;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    assign sram_rdata = {mem[1][sram_addr], mem[0][sram_addr]};

    always @(posedge CLK) begin
        if (poke_en)
            mem[poke_b][poke_a] = poke_d;
        if (sram_wen === 1'b1) begin
            for (int b = 0; b < 2; b++) begin
                if (sram_en[b] === 1'b0) begin
                    for (int k = 0; k < 4; k++) begin
                        if (sram_byte_en[k] === 1'b0)
                            mem[b][sram_addr][8*k +: 8] = sram_wdata[8*k +: 8];
                    end
                end
            end
        end
    end

    // Response scoreboard and SRAM activity monitor
    always @(negedge CLK) begin
        exp_t e;
        if (sram_wen === 1'b1) begin
            wr_cycles  = wr_cycles + 1;
            last_waddr = sram_addr;
            last_be    = sram_byte_en;
            last_en    = sram_en;
        end
        if (nRST === 1'b1 && sram_en !== 2'b11)
            en_cycles = en_cycles + 1;
        if (bus.resp_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected cyc=%0d rdata=%h", cyc,
                         bus.resp_rdata);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.due) begin
                    errors++;
                    $display("FAIL resp_cycle got=%0d exp=%0d", cyc, e.due);
                end
                checks++;
                if (bus.resp_error !== e.err) begin
                    errors++;
                    $display("FAIL resp_error got=%b exp=%b",
                             bus.resp_error, e.err);
                end
                if (e.chk) begin
                    checks++;
                    if (bus.resp_rdata !== e.data) begin
                        errors++;
                        $display("FAIL resp_rdata got=%h exp=%h",
                                 bus.resp_rdata, e.data);
                    end
                end
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            checks++;
            errors++;
            $display("FAIL resp_missing cyc=%0d due=%0d", cyc, sb[0].due);
            e = sb.pop_front();
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic poke(input int b, input logic [11:0] a,
                        input logic [31:0] d);
        poke_b  = b;
        poke_a  = a;
        poke_d  = d;
        poke_en = 1'b1;
        @(posedge CLK);
        #1;
        poke_en = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic wen,
                         input logic [1:0] s, input logic [31:0] d,
                         output int acc);
        bit got;
        got           = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_wen   = wen;
        bus.req_size  = s;
        bus.req_wdata = d;
        for (int n = 0; n < 64; n++) begin
            @(negedge CLK);
            if (bus.req_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (got)
            @(posedge CLK);
        #1;
        bus.req_valid = 1'b0;
        acc = cyc;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout addr=%h got=0 exp=1", a);
        end
    endtask

    task automatic push(input logic err, input logic chk,
                        input logic [31:0] data, input int due);
        exp_t e;
        e.err  = err;
        e.chk  = chk;
        e.data = data;
        e.due  = due;
        sb.push_back(e);
    endtask

    task automatic settle();
        repeat (14) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST          = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wen   = 1'b0;
        bus.req_size  = '0;
        bus.req_wdata = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks += 6;
        if (sram_en !== 2'b11) begin
            errors++;
            $display("FAIL rst_en got=%b exp=11", sram_en);
        end
        if (sram_byte_en !== 4'hF) begin
            errors++;
            $display("FAIL rst_be got=%h exp=f", sram_byte_en);
        end
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready got=%b exp=0", bus.req_ready);
        end
        if (bus.resp_valid !== 1'b0 || bus.resp_error !== 1'b0) begin
            errors++;
            $display("FAIL rst_resp got=%b%b exp=00", bus.resp_valid,
                     bus.resp_error);
        end
        if (bus.resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_rdata got=%h exp=0", bus.resp_rdata);
        end
        if (sram_wen !== 1'b0 || sram_addr !== 12'h0 ||
            sram_wdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_sram got=%b/%h/%h exp=0/0/0", sram_wen,
                     sram_addr, sram_wdata);
        end
        nRST = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rel_ready got=%b exp=1", bus.req_ready);
        end
    endtask

    task automatic test_byte_forward();
        int a1, a2, w0;
        poke(0, 12'h1, 32'h11223344);
        w0 = wr_cycles;
        issue(32'h5, 1'b1, 2'd0, {4{8'hAB}}, a1);
        push(1'b0, 1'b0, 32'h0, a1);
        issue(32'h4, 1'b0, 2'd2, 32'h0, a2);
        push(1'b0, 1'b1, 32'h1122AB44, a2 + 1 + W);
        repeat (W + 2) @(negedge CLK);
        checks++;
        if (wr_cycles !== w0) begin
            errors++;
            $display("FAIL fwd_nowrite got=%0d exp=%0d", wr_cycles, w0);
        end
        settle();
        checks++;
        if (mem[0][1] !== 32'h1122AB44) begin
            errors++;
            $display("FAIL fwd_commit got=%h exp=1122ab44", mem[0][1]);
        end
    endtask

    task automatic test_idle_drain();
        int a1, w0;
        w0 = wr_cycles;
        issue(32'h10, 1'b1, 2'd2, 32'hDEADBEEF, a1);
        push(1'b0, 1'b0, 32'h0, a1);
        settle();
        checks += 3;
        if (wr_cycles - w0 !== 1 + W) begin
            errors++;
            $display("FAIL drain_len got=%0d exp=%0d", wr_cycles - w0, 1 + W);
        end
        if (last_waddr !== 12'h4 || last_be !== 4'h0 ||
            last_en !== 2'b10) begin
            errors++;
            $display("FAIL drain_drive got=%h/%h/%b exp=004/0/10",
                     last_waddr, last_be, last_en);
        end
        if (mem[0][4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL drain_mem got=%h exp=deadbeef", mem[0][4]);
        end
        w0 = wr_cycles;
        settle();
        checks++;
        if (wr_cycles !== w0) begin
            errors++;
            $display("FAIL drain_empty got=%0d exp=%0d", wr_cycles, w0);
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2;
        poke(0, 12'h9, 32'h99999999);
        issue(32'h20, 1'b1, 2'd2, 32'h01020304, a1);
        push(1'b0, 1'b0, 32'h0, a1);
        issue(32'h24, 1'b1, 2'd2, 32'h05060708, a2);
        push(1'b0, 1'b0, 32'h0, a2 + 1 + W);
        repeat (W + 2) @(negedge CLK);
        checks += 2;
        if (mem[0][8] !== 32'h01020304) begin
            errors++;
            $display("FAIL b2b_first got=%h exp=01020304", mem[0][8]);
        end
        if (mem[0][9] !== 32'h99999999) begin
            errors++;
            $display("FAIL b2b_second_early got=%h exp=99999999", mem[0][9]);
        end
        settle();
        checks++;
        if (mem[0][9] !== 32'h05060708) begin
            errors++;
            $display("FAIL b2b_second got=%h exp=05060708", mem[0][9]);
        end
    endtask

    task automatic test_replicate();
        int a1;
        poke(0, 12'h0, 32'hAABBCCDD);
        issue(32'h2, 1'b0, 2'd1, 32'h0, a1);
        push(1'b0, 1'b1, 32'hAABBAABB, a1 + 1 + W);
        issue(32'h7, 1'b0, 2'd0, 32'h0, a1);
        push(1'b0, 1'b1, 32'h11111111, a1 + 1 + W);
        issue(32'h1, 1'b0, 2'd0, 32'h0, a1);
        push(1'b0, 1'b1, 32'hCCCCCCCC, a1 + 1 + W);
        settle();
    endtask

    task automatic test_banks();
        int a1;
        poke(1, 12'h4, 32'h55555555);
        issue(32'h4010, 1'b1, 2'd0, {4{8'hCD}}, a1);
        push(1'b0, 1'b0, 32'h0, a1);
        issue(32'h10, 1'b0, 2'd2, 32'h0, a1);
        push(1'b0, 1'b1, 32'hDEADBEEF, a1 + 1 + W);
        issue(32'h4010, 1'b0, 2'd2, 32'h0, a1);
        push(1'b0, 1'b1, 32'h555555CD, a1 + 1 + W);
        settle();
        checks += 2;
        if (mem[1][4] !== 32'h555555CD) begin
            errors++;
            $display("FAIL bank1_mem got=%h exp=555555cd", mem[1][4]);
        end
        if (mem[0][4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bank0_mem got=%h exp=deadbeef", mem[0][4]);
        end
    endtask

    task automatic test_illegal();
        int a1, e0, w0;
        e0 = en_cycles;
        w0 = wr_cycles;
        issue(32'h8, 1'b0, 2'd3, 32'h0, a1);
        push(1'b1, 1'b1, 32'hBAD1BAD1, a1);
        issue(32'h8, 1'b1, 2'd3, 32'hFFFFFFFF, a1);
        push(1'b1, 1'b1, 32'hBAD1BAD1, a1);
        settle();
        checks += 3;
        if (en_cycles !== e0) begin
            errors++;
            $display("FAIL err_en got=%0d exp=%0d", en_cycles, e0);
        end
        if (wr_cycles !== w0) begin
            errors++;
            $display("FAIL err_write got=%0d exp=%0d", wr_cycles, w0);
        end
        if (mem[0][2] === 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL err_mem got=%h exp=not ffffffff", mem[0][2]);
        end
    endtask

    initial begin
        test_reset();
        test_byte_forward();
        test_idle_drain();
        test_back_to_back();
        test_replicate();
        test_banks();
        test_illegal();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_left got=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
